// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared constants for the main memory block:
//   - FSM state encoding (IDLE, WAIT, DONE, HOLD)
//   - default access latency and latency counter width
//   - helper that converts a latency value into the counter load value
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam int LATENCY_DEFAULT = 4;

    // Four bits covers the supported latency range of 1..15.
    localparam int CNT_W = 4;

    // The counter is loaded with LATENCY-1 on accept and WAIT leaves when it
    // reads zero, which gives LATENCY+1 cycles from accept to done pulse.
    function automatic logic [CNT_W-1:0] latency_load(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_block_array.sv
// ---------------------------------------------------------------------------
// mem_block_array
//   Single-port block storage with a per-bit write mask and a registered read
//   port. Only the read register is reset; stored contents survive reset.
//
//   Ports:
//     clk_i    in   clock, rising edge
//     rst_ni   in   asynchronous active-low reset (read register only)
//     en_i     in   access strobe for this cycle
//     we_i     in   1 = masked write, 0 = read into rdata_o
//     addr_i   in   block index
//     wdata_i  in   write data
//     mask_i   in   per-bit write mask, 1 = bit written
//     rdata_o  out  registered read data, held until the next read
// ---------------------------------------------------------------------------
module mem_block_array #(
    parameter int WIDTH     = 512,
    parameter int DEPTH_LOG = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [DEPTH_LOG-1:0] addr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic [WIDTH-1:0]     mask_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] mem_q [0:(1 << DEPTH_LOG)-1];
    logic [WIDTH-1:0] rdata_q;

    // Storage carries no reset so a reset never disturbs stored blocks.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= (mem_q[addr_i] & ~mask_i) | (wdata_i & mask_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_block.sv
// ---------------------------------------------------------------------------
// main_memory_block
//   Block-granular main memory model with a fixed access latency. A level
//   request is accepted in IDLE, waits LATENCY cycles, completes with a
//   one-cycle done pulse, then HOLDs until the requester drops its enable so
//   the same request is never served twice. Writes win over reads when both
//   are raised together; the read is then served after the write.
//
//   Handshake: an enable is a level request that the requester keeps high
//   until it sees the matching one-cycle done pulse and then drops it. The
//   access is committed at accept; dropping the enable early does not abort
//   it. MEM_data_get changes only on the edge that raises read_done.
//
//   Ports:
//     clk                     in   clock, rising edge
//     rst                     in   asynchronous active-low reset
//     MEM_data_read_enable    in   read request (level)
//     MEM_data_write_enable   in   write request (level)
//     MEM_data_read_address   in   read byte address
//     MEM_data_write_address  in   write byte address
//     MEM_data_give           in   write data
//     MEM_data_mask           in   per-bit write mask, 1 = bit written
//     MEM_data_get            out  read data
//     MEM_data_read_done      out  one-cycle read completion pulse
//     MEM_data_write_done     out  one-cycle write completion pulse
//     stat_reads/stat_writes  out  saturating 16-bit completion counters
//                                  (only with MAIN_MEMORY_STATS_EN defined)
//     dbg_state_o             out  current FSM state (mem_pkg encoding)
//
//   Build option: define MAIN_MEMORY_STATS_EN to add the statistics counters.
// ---------------------------------------------------------------------------
module main_memory_block
    import mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH        = 32,
    parameter int BLOCK_WIDTH          = 512,
    parameter int BLOCK_WIDTH_WORD_log = 4,
    parameter int MEM_DEPTH_LOG        = 6,
    parameter int LATENCY              = LATENCY_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     MEM_data_read_enable,
    input  logic                     MEM_data_write_enable,
    input  logic [ADDRESS_WIDTH-1:0] MEM_data_read_address,
    input  logic [ADDRESS_WIDTH-1:0] MEM_data_write_address,
    input  logic [BLOCK_WIDTH-1:0]   MEM_data_give,
    input  logic [BLOCK_WIDTH-1:0]   MEM_data_mask,
    output logic [BLOCK_WIDTH-1:0]   MEM_data_get,
    output logic                     MEM_data_read_done,
    output logic                     MEM_data_write_done,
`ifdef MAIN_MEMORY_STATS_EN
    output logic [15:0]              stat_reads,
    output logic [15:0]              stat_writes,
`endif
    output logic [1:0]               dbg_state_o
);

    localparam int IDX_LSB = BLOCK_WIDTH_WORD_log + 2;

    logic [1:0]               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     is_write_q, is_write_d;
    logic [MEM_DEPTH_LOG-1:0] idx_q, idx_d;
    logic [BLOCK_WIDTH-1:0]   give_q, mask_q;
    logic                     capture_en;
    logic                     rd_done_q, wr_done_q;
    logic                     served_en;
    logic                     array_en;

    logic [MEM_DEPTH_LOG-1:0] rd_idx, wr_idx;

    // Only the block-index field of each address matters; the remaining
    // bits are folded into a sink so they are visibly ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{MEM_data_read_address, MEM_data_write_address};

    assign rd_idx = MEM_data_read_address[IDX_LSB +: MEM_DEPTH_LOG];
    assign wr_idx = MEM_data_write_address[IDX_LSB +: MEM_DEPTH_LOG];

    // HOLD watches the enable of the request that was just served.
    assign served_en = is_write_q ? MEM_data_write_enable : MEM_data_read_enable;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        capture_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (MEM_data_write_enable) begin
                    is_write_d = 1'b1;
                    idx_d      = wr_idx;
                    cnt_d      = latency_load(LATENCY);
                    capture_en = 1'b1;
                    state_d    = WAIT;
                end else if (MEM_data_read_enable) begin
                    is_write_d = 1'b0;
                    idx_d      = rd_idx;
                    cnt_d      = latency_load(LATENCY);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!served_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            rd_done_q  <= 1'b0;
            wr_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            // Raised on the same edge the array commits the access.
            rd_done_q  <= (state_q == DONE) && !is_write_q;
            wr_done_q  <= (state_q == DONE) && is_write_q;
        end
    end

    // Write payload needs no reset: it is only consumed after a fresh accept.
    always_ff @(posedge clk) begin
        if (capture_en) begin
            give_q <= MEM_data_give;
            mask_q <= MEM_data_mask;
        end
    end

    assign array_en = (state_q == DONE);

    mem_block_array #(
        .WIDTH     (BLOCK_WIDTH),
        .DEPTH_LOG (MEM_DEPTH_LOG)
    ) u_array (
        .clk_i   (clk),
        .rst_ni  (rst),
        .en_i    (array_en),
        .we_i    (is_write_q),
        .addr_i  (idx_q),
        .wdata_i (give_q),
        .mask_i  (mask_q),
        .rdata_o (MEM_data_get)
    );

    assign MEM_data_read_done  = rd_done_q;
    assign MEM_data_write_done = wr_done_q;
    assign dbg_state_o         = state_q;

`ifdef MAIN_MEMORY_STATS_EN
    logic [15:0] stat_reads_q, stat_writes_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
        end else if (state_q == DONE) begin
            if (!is_write_q && stat_reads_q != 16'hFFFF) begin
                stat_reads_q <= stat_reads_q + 16'd1;
            end
            if (is_write_q && stat_writes_q != 16'hFFFF) begin
                stat_writes_q <= stat_writes_q + 16'd1;
            end
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
`endif

endmodule

// File: tb/tb_main_memory_block.sv
// ---------------------------------------------------------------------------
// tb_main_memory_block
//   Self-checking bench for main_memory_block with the default parameters.
//   Expected contents come from a block-array reference model updated with
//   (old & ~mask) | (give & mask); timing expectations come from LATENCY.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_main_memory_block;
    import mem_pkg::*;

    localparam int AW      = 32;
    localparam int BW      = 512;
    localparam int WLOG    = 4;
    localparam int DLOG    = 6;
    localparam int L       = 4;
    localparam int DEPTH   = 1 << DLOG;
    localparam int BLK_B   = 4 << WLOG;   // bytes per block
    localparam int TIMEOUT = 60;

    logic          clk;
    logic          rst;
    logic          MEM_data_read_enable;
    logic          MEM_data_write_enable;
    logic [AW-1:0] MEM_data_read_address;
    logic [AW-1:0] MEM_data_write_address;
    logic [BW-1:0] MEM_data_give;
    logic [BW-1:0] MEM_data_mask;
    logic [BW-1:0] MEM_data_get;
    logic          MEM_data_read_done;
    logic          MEM_data_write_done;
    logic [1:0]    dbg_state_o;
`ifdef MAIN_MEMORY_STATS_EN
    logic [15:0]   stat_reads;
    logic [15:0]   stat_writes;
`endif

    int checks;
    int fails;

    logic [BW-1:0] exp_mem [DEPTH];
    bit            exp_valid [DEPTH];
    logic [BW-1:0] exp_get;

    main_memory_block #(
        .ADDRESS_WIDTH        (AW),
        .BLOCK_WIDTH          (BW),
        .BLOCK_WIDTH_WORD_log (WLOG),
        .MEM_DEPTH_LOG        (DLOG),
        .LATENCY              (L)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .MEM_data_read_enable   (MEM_data_read_enable),
        .MEM_data_write_enable  (MEM_data_write_enable),
        .MEM_data_read_address  (MEM_data_read_address),
        .MEM_data_write_address (MEM_data_write_address),
        .MEM_data_give          (MEM_data_give),
        .MEM_data_mask          (MEM_data_mask),
        .MEM_data_get           (MEM_data_get),
        .MEM_data_read_done     (MEM_data_read_done),
        .MEM_data_write_done    (MEM_data_write_done),
`ifdef MAIN_MEMORY_STATS_EN
        .stat_reads             (stat_reads),
        .stat_writes            (stat_writes),
`endif
        .dbg_state_o            (dbg_state_o)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] v;
        for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic int idx_of(input logic [AW-1:0] a);
        return int'((a / BLK_B) % DEPTH);
    endfunction

    // Byte address for a block index with random junk in the ignored bits.
    function automatic logic [AW-1:0] addr_for(input int idx);
        logic [AW-1:0] r;
        r = $urandom();
        return (r % BLK_B) + AW'(idx) * BLK_B + (r / (BLK_B * DEPTH)) * (BLK_B * DEPTH);
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_get = '0;
    endtask

    // Full write handshake. cyc = falling edges from raising the enable to
    // seeing write_done; stray = unexpected done pulses seen along the way.
    task automatic do_write(input logic [AW-1:0] addr, input logic [BW-1:0] data,
                            input logic [BW-1:0] mask, output int cyc, output int stray);
        int idx;
        MEM_data_write_address = addr;
        MEM_data_give          = data;
        MEM_data_mask          = mask;
        MEM_data_write_enable  = 1'b1;
        cyc   = 0;
        stray = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (MEM_data_read_done) stray++;
        end while (!MEM_data_write_done && cyc < TIMEOUT);
        MEM_data_write_enable = 1'b0;
        @(negedge clk);
        if (MEM_data_write_done || MEM_data_read_done) stray++;
        idx = idx_of(addr);
        exp_mem[idx]   = (exp_mem[idx] & ~mask) | (data & mask);
        exp_valid[idx] = 1'b1;
    endtask

    // Full read handshake; got is sampled with the done pulse, got_after one
    // cycle later.
    task automatic do_read(input logic [AW-1:0] addr, output int cyc, output int stray,
                           output logic [BW-1:0] got, output logic [BW-1:0] got_after);
        MEM_data_read_address = addr;
        MEM_data_read_enable  = 1'b1;
        cyc   = 0;
        stray = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (MEM_data_write_done) stray++;
        end while (!MEM_data_read_done && cyc < TIMEOUT);
        got = MEM_data_get;
        MEM_data_read_enable = 1'b0;
        @(negedge clk);
        if (MEM_data_write_done || MEM_data_read_done) stray++;
        got_after = MEM_data_get;
        exp_get = exp_mem[idx_of(addr)];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        MEM_data_read_enable   = 1'b0;
        MEM_data_write_enable  = 1'b0;
        MEM_data_read_address  = '0;
        MEM_data_write_address = '0;
        MEM_data_give          = '0;
        MEM_data_mask          = '0;
        #1;
        checks++;
        if (MEM_data_get !== '0) begin fails++; $display("FAIL reset_get: got %h required 0", MEM_data_get); end
        checks++;
        if ({MEM_data_read_done, MEM_data_write_done} !== 2'b00) begin
            fails++; $display("FAIL reset_done: got %b required 00", {MEM_data_read_done, MEM_data_write_done});
        end
        checks++;
        if (dbg_state_o !== IDLE) begin fails++; $display("FAIL reset_state: got %0d required %0d", dbg_state_o, IDLE); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_get = '0;
        @(negedge clk);
    endtask

    task automatic test_read_latency();
        int cyc, stray;
        logic [BW-1:0] d, got, got_after;
        d = rand_block();
        do_write(32'h40, d, {BW{1'b1}}, cyc, stray);
        checks++;
        if (cyc !== L + 2) begin fails++; $display("FAIL write_latency: got %0d required %0d", cyc - 1, L + 1); end
        pulse_reset();
        do_read(32'h40, cyc, stray, got, got_after);
        checks++;
        if (cyc !== L + 2) begin fails++; $display("FAIL read_latency: got %0d required %0d", cyc - 1, L + 1); end
        checks++;
        if (got !== exp_mem[idx_of(32'h40)]) begin fails++; $display("FAIL read_data_after_reset: got %h required %h", got, exp_mem[idx_of(32'h40)]); end
        checks++;
        if (stray !== 0) begin fails++; $display("FAIL read_single_pulse: got %0d stray pulses required 0", stray); end
    endtask

    task automatic test_mask_write();
        int cyc, stray;
        logic [BW-1:0] a5, m, got, got_after, old;
        do_write(32'h80, rand_block(), {BW{1'b1}}, cyc, stray);
        old = exp_mem[idx_of(32'h80)];
        a5 = {(BW/8){8'hA5}};
        m  = '0;
        m[15:0] = 16'hFFFF;
        do_write(32'h80, a5, m, cyc, stray);
        checks++;
        if (stray !== 0) begin fails++; $display("FAIL mask_write_pulse: got %0d stray pulses required 0", stray); end
        do_read(32'h80, cyc, stray, got, got_after);
        checks++;
        if (got[15:0] !== 16'hA5A5) begin fails++; $display("FAIL mask_low_bits: got %h required a5a5", got[15:0]); end
        checks++;
        if (got[BW-1:16] !== old[BW-1:16]) begin fails++; $display("FAIL mask_high_bits: got %h required %h", got[BW-1:16], old[BW-1:16]); end
    endtask

    task automatic test_random_ops();
        int cyc, stray, idx;
        logic [BW-1:0] d, m, got, got_after;
        for (int n = 0; n < 16; n++) begin
            idx = $urandom_range(0, 7);
            if (exp_valid[idx] && $urandom_range(0, 1) == 1) begin
                do_read(addr_for(idx), cyc, stray, got, got_after);
                checks++;
                if (got !== exp_mem[idx]) begin fails++; $display("FAIL rand_read[%0d]: got %h required %h", n, got, exp_mem[idx]); end
                checks++;
                if (got_after !== exp_mem[idx]) begin fails++; $display("FAIL rand_get_stable[%0d]: got %h required %h", n, got_after, exp_mem[idx]); end
            end else begin
                d = rand_block();
                case ($urandom_range(0, 3))
                    0:       m = '0;
                    1:       m = {BW{1'b1}};
                    default: m = rand_block();
                endcase
                do_write(addr_for(idx), d, m, cyc, stray);
            end
            checks++;
            if (cyc !== L + 2) begin fails++; $display("FAIL rand_latency[%0d]: got %0d required %0d", n, cyc - 1, L + 1); end
            checks++;
            if (stray !== 0) begin fails++; $display("FAIL rand_stray[%0d]: got %0d required 0", n, stray); end
        end
        // An all-zero mask must complete yet leave the block untouched.
        idx = 9;
        do_write(addr_for(idx), rand_block(), {BW{1'b1}}, cyc, stray);
        do_write(addr_for(idx), rand_block(), '0, cyc, stray);
        checks++;
        if (cyc !== L + 2) begin fails++; $display("FAIL zero_mask_done: got %0d required %0d", cyc - 1, L + 1); end
        do_read(addr_for(idx), cyc, stray, got, got_after);
        checks++;
        if (got !== exp_mem[idx]) begin fails++; $display("FAIL zero_mask_data: got %h required %h", got, exp_mem[idx]); end
    endtask

    task automatic test_both_enables();
        int cyc, cyc2, stray;
        logic [BW-1:0] d;
        d = rand_block();
        MEM_data_write_address = addr_for(4);
        MEM_data_read_address  = addr_for(4);
        MEM_data_give          = d;
        MEM_data_mask          = {BW{1'b1}};
        MEM_data_write_enable  = 1'b1;
        MEM_data_read_enable   = 1'b1;
        cyc = 0; stray = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (MEM_data_read_done) stray++;
        end while (!MEM_data_write_done && cyc < TIMEOUT);
        checks++;
        if (cyc !== L + 2) begin fails++; $display("FAIL both_write_first: got %0d required %0d", cyc - 1, L + 1); end
        checks++;
        if (stray !== 0) begin fails++; $display("FAIL both_read_early: got %0d read pulses required 0", stray); end
        exp_mem[4] = d;
        exp_valid[4] = 1'b1;
        // Dropping the write leaves HOLD; one IDLE cycle, then the read is
        // accepted and completes LATENCY+1 cycles later.
        MEM_data_write_enable = 1'b0;
        cyc2 = 0;
        do begin
            @(negedge clk);
            cyc2++;
            if (MEM_data_write_done) stray++;
        end while (!MEM_data_read_done && cyc2 < TIMEOUT);
        checks++;
        if (cyc2 !== L + 3) begin fails++; $display("FAIL both_read_after: got %0d required %0d", cyc2, L + 3); end
        checks++;
        if (MEM_data_get !== d) begin fails++; $display("FAIL both_read_data: got %h required %h", MEM_data_get, d); end
        checks++;
        if (stray !== 0) begin fails++; $display("FAIL both_write_repeat: got %0d required 0", stray); end
        MEM_data_read_enable = 1'b0;
        exp_get = d;
        @(negedge clk);
    endtask

    task automatic test_held_read();
        int pulses;
        pulses = 0;
        MEM_data_read_address = addr_for(4);
        MEM_data_read_enable  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (MEM_data_read_done) pulses++;
        end
        MEM_data_read_enable = 1'b0;
        @(negedge clk);
        if (MEM_data_read_done) pulses++;
        checks++;
        if (pulses !== 1) begin fails++; $display("FAIL held_read_pulses: got %0d required 1", pulses); end
        checks++;
        if (MEM_data_get !== exp_mem[4]) begin fails++; $display("FAIL held_read_data: got %h required %h", MEM_data_get, exp_mem[4]); end
        exp_get = exp_mem[4];
    endtask

    task automatic test_drop_in_wait();
        int cyc;
        MEM_data_read_address = addr_for(9);
        MEM_data_read_enable  = 1'b1;
        @(negedge clk);
        MEM_data_read_enable = 1'b0;   // accepted on the previous edge
        cyc = 1;
        do begin
            @(negedge clk);
            cyc++;
        end while (!MEM_data_read_done && cyc < TIMEOUT);
        checks++;
        if (cyc !== L + 2) begin fails++; $display("FAIL drop_wait_done: got %0d required %0d", cyc - 1, L + 1); end
        checks++;
        if (MEM_data_get !== exp_mem[9]) begin fails++; $display("FAIL drop_wait_data: got %h required %h", MEM_data_get, exp_mem[9]); end
        exp_get = exp_mem[9];
        @(negedge clk);
        checks++;
        if (dbg_state_o !== IDLE) begin fails++; $display("FAIL drop_wait_idle: got %0d required %0d", dbg_state_o, IDLE); end
    endtask

    task automatic test_get_stable();
        int cyc, stray;
        do_write(addr_for(5), rand_block(), {BW{1'b1}}, cyc, stray);
        repeat (3) @(negedge clk);
        checks++;
        if (MEM_data_get !== exp_get) begin fails++; $display("FAIL get_stable: got %h required %h", MEM_data_get, exp_get); end
    endtask

    task automatic test_reset_in_wait();
        int cyc, stray, pulses;
        logic [BW-1:0] got, got_after, old;
        old = exp_mem[4];
        MEM_data_write_address = addr_for(4);
        MEM_data_give          = rand_block();
        MEM_data_mask          = {BW{1'b1}};
        MEM_data_write_enable  = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (MEM_data_write_done || MEM_data_read_done) pulses++;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dbg_state_o !== IDLE) begin fails++; $display("FAIL async_reset_state: got %0d required %0d", dbg_state_o, IDLE); end
        checks++;
        if (MEM_data_get !== '0) begin fails++; $display("FAIL async_reset_get: got %h required 0", MEM_data_get); end
        MEM_data_write_enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_get = '0;
        repeat (L + 4) begin
            @(negedge clk);
            if (MEM_data_write_done || MEM_data_read_done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin fails++; $display("FAIL reset_wait_pulse: got %0d required 0", pulses); end
        do_read(addr_for(4), cyc, stray, got, got_after);
        checks++;
        if (got !== old) begin fails++; $display("FAIL reset_wait_unchanged: got %h required %h", got, old); end
    endtask

`ifdef MAIN_MEMORY_STATS_EN
    task automatic test_stats();
        int cyc, stray;
        logic [BW-1:0] got, got_after;
        pulse_reset();
        checks++;
        if ({stat_reads, stat_writes} !== 32'd0) begin fails++; $display("FAIL stats_clear: got %0d/%0d required 0/0", stat_reads, stat_writes); end
        for (int i = 0; i < 3; i++) do_read(addr_for(4), cyc, stray, got, got_after);
        for (int i = 0; i < 2; i++) do_write(addr_for(6), rand_block(), rand_block(), cyc, stray);
        checks++;
        if (stat_reads !== 16'd3) begin fails++; $display("FAIL stats_reads: got %0d required 3", stat_reads); end
        checks++;
        if (stat_writes !== 16'd2) begin fails++; $display("FAIL stats_writes: got %0d required 2", stat_writes); end
        pulse_reset();
        checks++;
        if ({stat_reads, stat_writes} !== 32'd0) begin fails++; $display("FAIL stats_reset: got %0d/%0d required 0/0", stat_reads, stat_writes); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        fails  = 0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i]   = '0;
            exp_valid[i] = 1'b0;
        end
        test_reset();
        test_read_latency();
        test_mask_write();
        test_random_ops();
        test_both_enables();
        test_held_read();
        test_drop_in_wait();
        test_get_stable();
        test_reset_in_wait();
`ifdef MAIN_MEMORY_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
